// File: rtl/sync_fifo_pkg.sv
// Shared constants and output-stage state encodings for the sync FIFO
// read and write controllers.
package sync_fifo_pkg;

    localparam int AW_DEF = 3;
    localparam int DW_DEF = 32;
    localparam int PW_DEF = AW_DEF + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } ostate_e;

endpackage

// File: rtl/sync_fiford_ostage.sv
// FWFT output stage: two-entry skid buffer fed by one-cycle-latency
// memory reads, presenting a registered head entry to the consumer.
module sync_fiford_ostage
    import sync_fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          ren_i,
    input  logic          rfifo_i,
    input  logic [DW-1:0] rdata_i,
    output logic          fetch_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    ostate_e       state_q, state_d;
    logic          infl_q;
    logic          hv_q, hv_d;
    logic          tv_q, tv_d;
    logic [DW-1:0] h_q, h_d;
    logic [DW-1:0] t_q, t_d;
    logic          pop;

    assign pop      = hv_q & rfifo_i;
    assign fetch_o  = (state_q != S_TWO) | pop;
    assign rvalid_o = hv_q;
    assign rdata_o  = h_q;

    always_comb begin
        h_d     = h_q;
        t_d     = t_q;
        hv_d    = hv_q;
        tv_d    = tv_q;
        state_d = state_q;
        if (pop) begin
            h_d  = t_q;
            hv_d = tv_q;
            tv_d = 1'b0;
        end
        // returning word lands in the first free slot after any pop
        if (infl_q) begin
            if (!hv_d) begin
                h_d  = rdata_i;
                hv_d = 1'b1;
            end else begin
                t_d  = rdata_i;
                tv_d = 1'b1;
            end
        end
        unique case (state_q)
            S_EMPTY: if (ren_i) state_d = S_ONE;
            S_ONE: begin
                if (ren_i && !pop) state_d = S_TWO;
                else if (!ren_i && pop) state_d = S_EMPTY;
            end
            S_TWO: if (pop && !ren_i) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            infl_q  <= 1'b0;
            hv_q    <= 1'b0;
            tv_q    <= 1'b0;
            h_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= ren_i;
            hv_q    <= hv_d;
            tv_q    <= tv_d;
            h_q     <= h_d;
            t_q     <= t_d;
        end
    end

endmodule

// File: rtl/sync_fiford_ctrl.sv
// Sync FIFO read controller; define SYNC_FIFORD_FWFT_EN for
// first-word-fall-through mode, otherwise standard read-request mode.
module sync_fiford_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          rfifo_i,
    input  logic [AW:0]   wptr_i,
    input  logic [DW-1:0] rdata_i,
    output logic          ren_o,
    output logic [AW-1:0] raddr_o,
    output logic [AW:0]   rptr_o,
    output logic          rempty_o,
    output logic [AW:0]   rlevel_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    logic [AW:0] rptr_q, rptr_d;
    logic        rempty_q, rempty_d;
    logic        fetch;

    assign ren_o    = fetch & ~rempty_q;
    assign rptr_d   = ren_o ? rptr_q + 1'b1 : rptr_q;
    // empty lags a write by one edge, so it can only err towards empty
    assign rempty_d = (rptr_d == wptr_i);

    assign raddr_o  = rptr_q[AW-1:0];
    assign rptr_o   = rptr_q;
    assign rempty_o = rempty_q;
    assign rlevel_o = wptr_i - rptr_q;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
        end
    end

`ifdef SYNC_FIFORD_FWFT_EN
    sync_fiford_ostage #(
        .DW(DW)
    ) u_ost (
        .wclk    (wclk),
        .rst_n   (rst_n),
        .ren_i   (ren_o),
        .rfifo_i (rfifo_i),
        .rdata_i (rdata_i),
        .fetch_o (fetch),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o)
    );
`else
    logic rvalid_q;

    assign fetch    = rfifo_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rvalid_q ? rdata_i : '0;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) rvalid_q <= 1'b0;
        else        rvalid_q <= ren_o;
    end
`endif

endmodule

// File: tb/tb_sync_fiford_ctrl.sv
// Self-checking bench for sync_fiford_ctrl with a queue-based reference
// model of the FIFO contents and a one-cycle-latency memory.
module tb_sync_fiford_ctrl;
    import sync_fifo_pkg::*;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          wclk = 1'b0;
    logic          rst_n;
    logic          rfifo_i;
    logic [AW:0]   wptr_i;
    logic [DW-1:0] rdata_i;
    logic          ren_o;
    logic [AW-1:0] raddr_o;
    logic [AW:0]   rptr_o;
    logic          rempty_o;
    logic [AW:0]   rlevel_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;

    logic [DW-1:0] mem [8];

    int checks = 0;
    int errors = 0;

    // reference model: words written but not yet read, in order
    logic [DW-1:0] q[$];
    int            wr_n;
    int            rd_n;
    bit            emp_m;
    bit            rv_m;
    logic [DW-1:0] dat_m;

    sync_fiford_ctrl #(.AW(AW), .DW(DW)) dut (
        .wclk    (wclk),
        .rst_n   (rst_n),
        .rfifo_i (rfifo_i),
        .wptr_i  (wptr_i),
        .rdata_i (rdata_i),
        .ren_o   (ren_o),
        .raddr_o (raddr_o),
        .rptr_o  (rptr_o),
        .rempty_o(rempty_o),
        .rlevel_o(rlevel_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) begin
        if (ren_o) rdata_i <= mem[raddr_o];
    end

    task automatic model_clear();
        q.delete();
        wr_n  = 0;
        rd_n  = 0;
        emp_m = 1'b1;
        rv_m  = 1'b0;
        dat_m = '0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        rfifo_i = 1'b0;
        wptr_i  = '0;
        model_clear();
        repeat (2) @(negedge wclk);
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wptr_i[AW-1:0]] = d;
        wptr_i = wptr_i + 1'b1;
        q.push_back(d);
        wr_n++;
    endtask

    // standard mode: a request is served whenever the FIFO was seen non-empty
    task automatic model_edge();
        bit r;
        @(posedge wclk);
        r = rfifo_i & ~emp_m;
        rv_m = r;
        if (r) begin
            dat_m = q.pop_front();
            rd_n++;
        end
        emp_m = (rd_n == wr_n);
        @(negedge wclk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rempty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_rempty got %b want 1", rempty_o);
        end
        checks++;
        if (rptr_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rptr got %b want 0000", rptr_o);
        end
        checks++;
        if (rlevel_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_rlevel got %0d want 0", rlevel_o);
        end
        checks++;
        if (rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid got %b want 0", rvalid_o);
        end
        checks++;
        if (ren_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ren got %b want 0", ren_o);
        end
    endtask

`ifndef SYNC_FIFORD_FWFT_EN
    task automatic test_single_write();
        logic [DW-1:0] w;
        w = 32'hA5A5_0001;
        do_reset();
        write_word(w);
        #1;
        checks++;
        if (rempty_o !== 1'b1) begin
            errors++;
            $display("FAIL single_early_empty got %b want 1", rempty_o);
        end
        model_edge();
        #1;
        checks++;
        if (rempty_o !== 1'b0) begin
            errors++;
            $display("FAIL single_nonempty got %b want 0", rempty_o);
        end
        rfifo_i = 1'b1;
        #1;
        checks++;
        if (ren_o !== 1'b1 || raddr_o !== 3'd0) begin
            errors++;
            $display("FAIL single_ren got %b/%0d want 1/0", ren_o, raddr_o);
        end
        model_edge();
        rfifo_i = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== w) begin
            errors++;
            $display("FAIL single_data got %b/%h want 1/%h",
                     rvalid_o, rdata_o, w);
        end
        checks++;
        if (rptr_o !== 4'd1 || rempty_o !== 1'b1) begin
            errors++;
            $display("FAIL single_after got %0d/%b want 1/1",
                     rptr_o, rempty_o);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w [8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w[i] = $urandom;
            write_word(w[i]);
        end
        #1;
        checks++;
        if (rlevel_o !== 4'd8) begin
            errors++;
            $display("FAIL wrap_level got %0d want 8", rlevel_o);
        end
        model_edge();
        rfifo_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (ren_o !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ren k=%0d got %b want 1", k, ren_o);
            end
            if (k > 0) begin
                checks++;
                if (rvalid_o !== 1'b1 || rdata_o !== w[k-1]) begin
                    errors++;
                    $display("FAIL wrap_data k=%0d got %b/%h want 1/%h",
                             k, rvalid_o, rdata_o, w[k-1]);
                end
            end
            model_edge();
        end
        #1;
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== w[7]) begin
            errors++;
            $display("FAIL wrap_last got %b/%h want 1/%h",
                     rvalid_o, rdata_o, w[7]);
        end
        checks++;
        if (rptr_o !== 4'b1000 || rempty_o !== 1'b1 || ren_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got %b/%b/%b want 1000/1/0",
                     rptr_o, rempty_o, ren_o);
        end
        model_edge();
        #1;
        checks++;
        if (rptr_o !== 4'b1000 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ninth got %b/%b want 1000/0",
                     rptr_o, rvalid_o);
        end
        rfifo_i = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        rfifo_i = 1'b1;
        repeat (5) begin
            #1;
            checks++;
            if (ren_o !== 1'b0 || rptr_o !== 4'd0 || rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL underflow got %b/%0d/%b want 0/0/0",
                         ren_o, rptr_o, rvalid_o);
            end
            model_edge();
        end
        rfifo_i = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && (wr_n - rd_n) < 8)
                write_word($urandom);
            rfifo_i = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (ren_o !== (rfifo_i & ~emp_m) || rempty_o !== emp_m) begin
                errors++;
                $display("FAIL rand_ctl i=%0d got %b/%b want %b/%b",
                         i, ren_o, rempty_o, rfifo_i & ~emp_m, emp_m);
            end
            checks++;
            if (rptr_o !== 4'(rd_n) || rlevel_o !== 4'(wr_n - rd_n)) begin
                errors++;
                $display("FAIL rand_ptr i=%0d got %0d/%0d want %0d/%0d",
                         i, rptr_o, rlevel_o, 4'(rd_n), wr_n - rd_n);
            end
            checks++;
            if (rvalid_o !== rv_m || (rv_m && rdata_o !== dat_m)) begin
                errors++;
                $display("FAIL rand_data i=%0d got %b/%h want %b/%h",
                         i, rvalid_o, rdata_o, rv_m, dat_m);
            end
            model_edge();
        end
        rfifo_i = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        write_word(32'hDEAD_BEEF);
        model_edge();
        rfifo_i = 1'b1;
        #1;
        checks++;
        if (ren_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ren got %b want 1", ren_o);
        end
        model_edge();
        rfifo_i = 1'b0;
        rst_n   = 1'b0;
        wptr_i  = '0;
        model_clear();
        #1;
        checks++;
        if (rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_reset got %b want 0", rvalid_o);
        end
        @(negedge wclk);
        rst_n = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if (rvalid_o !== 1'b0 || rptr_o !== 4'd0) begin
                errors++;
                $display("FAIL midrst_after got %b/%0d want 0/0",
                         rvalid_o, rptr_o);
            end
            @(negedge wclk);
        end
    endtask
`else
    task automatic test_fwft();
        logic [DW-1:0] w [4];
        int pulses;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            write_word(w[i]);
        end
        pulses = 0;
        repeat (6) begin
            #1;
            if (ren_o === 1'b1) pulses++;
            @(negedge wclk);
        end
        #1;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL fwft_pulses got %0d want 2", pulses);
        end
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== w[0]) begin
            errors++;
            $display("FAIL fwft_head got %b/%h want 1/%h",
                     rvalid_o, rdata_o, w[0]);
        end
        checks++;
        if (rlevel_o !== 4'd2 || dut.u_ost.state_q !== S_TWO) begin
            errors++;
            $display("FAIL fwft_fill got %0d/%0d want 2/%0d",
                     rlevel_o, dut.u_ost.state_q, S_TWO);
        end
        @(negedge wclk);
        #1;
        checks++;
        if (rdata_o !== w[0] || ren_o !== 1'b0) begin
            errors++;
            $display("FAIL fwft_hold got %h/%b want %h/0",
                     rdata_o, ren_o, w[0]);
        end
        rfifo_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rvalid_o !== 1'b1 || rdata_o !== w[k]) begin
                errors++;
                $display("FAIL fwft_stream k=%0d got %b/%h want 1/%h",
                         k, rvalid_o, rdata_o, w[k]);
            end
            @(negedge wclk);
        end
        #1;
        checks++;
        if (rvalid_o !== 1'b0 || dut.u_ost.state_q !== S_EMPTY) begin
            errors++;
            $display("FAIL fwft_drain got %b/%0d want 0/%0d",
                     rvalid_o, dut.u_ost.state_q, S_EMPTY);
        end
        rfifo_i = 1'b0;
    endtask
`endif

    initial begin
        rdata_i = '0;
        test_reset();
`ifndef SYNC_FIFORD_FWFT_EN
        test_single_write();
        test_wrap();
        test_underflow();
        test_random();
        test_reset_mid_read();
`else
        test_fwft();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fiford_ctrl.md
SYNC_FIFORD_CTRL -- requirements
Module: sync_fiford_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3: memory address width; depth = 2^AW.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have port wclk  input  1  clock, rising-edge; same clock as the write controller.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rfifo_i  input  1  read request (standard mode) or consumer ready (FWFT mode).
REQ-006 SHALL have port wptr_i  input  AW+1  write pointer from the write controller, including the wrap bit.
REQ-007 SHALL have port rdata_i  input  DW  memory read data, valid one cycle after ren_o.
REQ-008 SHALL have port ren_o  output  1  memory read enable.
REQ-009 SHALL have port raddr_o  output  AW  memory read address, equal to rptr[AW-1:0].
REQ-010 SHALL have port rptr_o  output  AW+1  read pointer, including the wrap bit, to the write controller.
REQ-011 SHALL have port rempty_o  output  1  memory empty flag, registered.
REQ-012 SHALL have port rlevel_o  output  AW+1  memory occupancy.
REQ-013 SHALL have port rvalid_o  output  1  rdata_o is valid.
REQ-014 SHALL have port rdata_o  output  DW  read data.

Function
REQ-015 SHALL generate ren_o = fetch & ~rempty; fetch is defined per mode; reads while empty are dropped and the pointer is held.
REQ-016 SHALL set nxt_rptr = rptr + 1 when ren_o is high, else rptr; the add wraps modulo 2^(AW+1).
REQ-017 SHALL register rempty from nxt_rempty = (nxt_rptr == wptr_i).
REQ-018 SHALL therefore report empty only conservatively: a write at edge N deasserts rempty_o at edge N+1, and rempty_o is never falsely low.
REQ-019 SHALL compute rlevel_o = wptr_i - rptr, modulo 2^(AW+1), combinationally; range 0..2^AW.
REQ-020 Standard mode: fetch = rfifo_i; rvalid_o SHALL be high for exactly the cycle after ren_o, with rdata_o = rdata_i (combinational pass-through).
REQ-021 Standard mode: back-to-back reads SHALL sustain one word per cycle.

Reset
REQ-022 On rst_n low, SHALL force, asynchronously: rptr = 0, rempty_o = 1, rvalid_o = 0, ren_o = 0, rdata_o = 0, output-stage state = S_EMPTY, in-flight flags = 0.
REQ-023 A reset during an in-flight read SHALL discard the returning data; rvalid_o SHALL stay 0 after release until a new fetch completes.

Configuration
REQ-024 Macro SYNC_FIFORD_FWFT_EN defined SHALL select first-word-fall-through mode; undefined SHALL select standard mode (REQ-020/021).
REQ-025 FWFT mode output stage:
- 2-entry buffer; cnt (0..2) counts stored plus in-flight words.
- pop = rvalid_o & rfifo_i.
- fetch = (cnt < 2) | pop.
- cnt_next = cnt + ren_o - pop.
REQ-026 FWFT FSM SHALL have states S_EMPTY (cnt=0), S_ONE (cnt=1) and S_TWO (cnt=2); transitions follow cnt_next, and simultaneous ren_o and pop hold the state.
REQ-027 FWFT mode SHALL present rvalid_o and rdata_o from a registered head entry.
REQ-028 FWFT mode SHALL hold rdata_o stable while rvalid_o & ~rfifo_i.
REQ-029 FWFT mode SHALL deliver data in order, with no loss or duplication, and sustain one word per cycle with rfifo_i held high.
REQ-030 In FWFT mode, rempty_o and rlevel_o SHALL describe memory contents only, excluding output-stage words.

Structure
REQ-031 Shared package sync_fifo_pkg SHALL hold the AW/DW defaults, the pointer-width constant, and the FWFT state encodings; the write controller SHALL use the same package.
REQ-032 The FWFT output stage SHALL be a sub-module sync_fiford_ostage, instantiated only under SYNC_FIFORD_FWFT_EN.

Verification
REQ-033 Reset check, AW=3: after reset, rempty_o=1, rptr_o=4'b0000, rlevel_o=0, rvalid_o=0, ren_o=0.
REQ-034 Single write, standard mode: wptr_i 0->1 at edge N -> rempty_o=0 at N+1; rfifo_i=1 -> ren_o=1 and raddr_o=0; then rvalid_o=1 with rdata_o = mem[0], rptr_o=1 and rempty_o=1.
REQ-035 Wrap, standard mode: wptr_i=4'b1000, rptr=4'b0000 -> rlevel_o=8; 8 reads -> rptr_o=4'b1000 and rempty_o=1; a 9th request -> ren_o=0 and rptr unchanged.
REQ-036 Underflow: rfifo_i held high for 5 cycles while empty -> ren_o=0, rptr_o constant, rvalid_o=0.
REQ-037 FWFT, 4 words A,B,C,D preloaded:
- rfifo_i low -> exactly 2 ren_o pulses; rvalid_o=1 with rdata_o=A held; rlevel_o=2; state S_TWO.
- rfifo_i then high -> A,B,C,D on 4 consecutive cycles; then rvalid_o=0 and state S_EMPTY.
REQ-038 Reset mid-read: assert rst_n in the cycle after ren_o -> rvalid_o never asserts for that word; rptr_o=0 after release.
